ineq_sweep_checker: RTL and testbench
=====================================

Name: ineq_sweep_checker

Overview:
- Synthesizable, self-checking stimulus/response engine for the 4-bit-in / 3-bit-out Inequality standard-form block.
- Drives the DUT's NUM input through all 16 codes and samples the DUT's OUT.
- Compares each sample against a parameterised truth table and reports pass/fail, error count and the first failing vector.
- Sits beside the DUT in on-board or simulation harnesses in place of hand-written per-vector asserts.

Parameters:
- SETTLE_CYCLES, 2: cycles NUM is held before OUT is sampled; legal range 1..15.
- EXP_TABLE, 48-bit table: expected OUT for each NUM; entry n occupies bits [3n+2:3n].
  - Default: OUT[2]=(n>=8), OUT[1]=(n>=4), OUT[0]=(n>=2), so n=8 gives 3'b111.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset sampled only on clk rising edge
- start  in  1  one-cycle pulse; begins a sweep when idle or done
- dut_out  in  3  OUT from the DUT
- num  out  4  NUM driven to the DUT
- busy  out  1  high while a sweep runs
- done  out  1  high after a sweep completes; held until the next start or reset
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  5  number of mismatching vectors, 0..16
- fail_valid  out  1  a first failure has been captured
- first_fail_num  out  4  NUM of the first mismatch
- first_fail_out  out  3  dut_out observed at the first mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-sweep aborts on that edge and clears every output; it has priority over start.
- States:
  - IDLE: start=1 -> DRIVE; num<=0, settle count<=0, err_count<=0, fail_valid<=0, first_fail_*<=0.
  - DRIVE: busy=1; count increments each cycle; at count==SETTLE_CYCLES-1 -> CHECK.
  - CHECK: busy=1; compare dut_out against EXP_TABLE[3*num +: 3].
    - Any bit differs, including X/Z in simulation (case-inequality): err_count+1.
    - If fail_valid=0, also capture first_fail_num<=num, first_fail_out<=dut_out, fail_valid<=1.
    - If num==15 -> DONE; otherwise num<=num+1, count<=0, -> DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0); num holds 15. start=1 -> same actions as IDLE start, and done drops next cycle.
- start while busy is ignored.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - A sweep takes 16*(SETTLE_CYCLES+1) cycles from the start edge to the edge that raises done.
  - num changes only on DRIVE entry.
- Arithmetic: err_count is 5 bits, so 16 mismatches fit without saturation. num wraps never occurs because 15 terminates the sweep.
- Results (err_count, first_fail_*, fail_valid, pass) stay stable in DONE until the next start or reset.

Decomposition:
- Package ineq_sweep_pkg holds:
  - State enum {IDLE, DRIVE, CHECK, DONE}.
  - Widths NUM_W=4, OUT_W=3, CNT_W=5.
  - Default-table constant DEFAULT_EXP_TABLE.
  - Function exp_lookup(table, n).
- One natural sub-module: ineq_expect_rom, a combinational EXP_TABLE index from num to the 3-bit expected value.
- FSM, counters and capture logic stay in the top.

Test Plan:
1. Golden DUT model matching the default table, SETTLE_CYCLES=2, start pulse at cycle 0 -> num steps 0..15 every 3 cycles; done=1 at cycle 48; pass=1, err_count=0, fail_valid=0.
2. DUT with OUT[0] stuck at 0 -> mismatches at n=2..15; err_count=14, pass=0, first_fail_num=2, first_fail_out=3'b000.
3. Single fault, DUT returns 3'b011 only at NUM=8 -> err_count=1, first_fail_num=8, first_fail_out=3'b011; done held for 10+ cycles with no change.
4. Reset asserted at cycle 20 mid-sweep -> next cycle all outputs 0, state IDLE; new start yields a clean 48-cycle sweep with pass=1.
5. start pulsed during busy at cycles 5 and 30 -> ignored, done still at 48. start in DONE -> restart, err_count cleared, done=0 one cycle later.
6. SETTLE_CYCLES=1 with dut_out driven X at NUM=5 -> sweep length 32 cycles, err_count=1, first_fail_num=5.

Source files
------------

// File: rtl/ineq_sweep_pkg.sv
// Shared types, widths and default truth table for the inequality sweep checker.
package ineq_sweep_pkg;

  localparam int unsigned NUM_W    = 4;
  localparam int unsigned OUT_W    = 3;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned TABLE_W  = OUT_W * (1 << NUM_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Entry n = {n>=8, n>=4, n>=2}; n=15 sits in the top three bits.
  localparam logic [TABLE_W-1:0] DEFAULT_EXP_TABLE = 48'hFFFF_FF6D_B240;

  function automatic logic [OUT_W-1:0] exp_lookup(input logic [TABLE_W-1:0] tbl,
                                                  input logic [NUM_W-1:0]   n);
    return tbl[OUT_W * int'(n) +: OUT_W];
  endfunction

endpackage

// File: rtl/ineq_expect_rom.sv
// Combinational truth-table lookup: NUM code to expected 3-bit OUT.
module ineq_expect_rom
  import ineq_sweep_pkg::*;
#(
  parameter logic [TABLE_W-1:0] EXP_TABLE = DEFAULT_EXP_TABLE
) (
  input  logic [NUM_W-1:0] i_num,
  output logic [OUT_W-1:0] o_exp
);

  always_comb begin
    o_exp = exp_lookup(EXP_TABLE, i_num);
  end

endmodule

// File: rtl/ineq_sweep_checker.sv
// Sweeps NUM through all 16 codes, samples DUT OUT after a settle delay and
// records error count plus the first failing vector.
module ineq_sweep_checker
  import ineq_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [TABLE_W-1:0] EXP_TABLE     = DEFAULT_EXP_TABLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OUT_W-1:0] dut_out,
  output logic [NUM_W-1:0] num,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [NUM_W-1:0] first_fail_num,
  output logic [OUT_W-1:0] first_fail_out
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_W-1:0]    NUM_LAST    = '1;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_W-1:0]     r_num;
  logic [SETTLE_W-1:0]  r_settle;
  logic [CNT_W-1:0]     r_err;
  logic                 r_fail_valid;
  logic [NUM_W-1:0]     r_ff_num;
  logic [OUT_W-1:0]     r_ff_out;
  logic [OUT_W-1:0]     w_exp;
  logic                 w_mismatch;
  logic                 w_start_go;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_pass;

  ineq_expect_rom #(
    .EXP_TABLE(EXP_TABLE)
  ) u_rom (
    .i_num(r_num),
    .o_exp(w_exp)
  );

  // Case-inequality so X/Z from the DUT counts as a mismatch in simulation.
  assign w_mismatch = (dut_out !== w_exp);
  assign w_start_go = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = DRIVE;
      DRIVE: if (r_settle == SETTLE_LAST) w_next = CHECK;
      CHECK: w_next = (r_num == NUM_LAST) ? DONE : DRIVE;
      DONE:  if (start) w_next = DRIVE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_pass = 1'b0;
    unique case (r_state)
      DRIVE, CHECK: w_busy = 1'b1;
      DONE: begin
        w_done = 1'b1;
        w_pass = (r_err == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num        <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_ff_num     <= '0;
      r_ff_out     <= '0;
    end else if (w_start_go) begin
      r_num        <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_ff_num     <= '0;
      r_ff_out     <= '0;
    end else begin
      if (r_state == DRIVE) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end
      if (r_state == CHECK) begin
        if (w_mismatch) begin
          r_err <= r_err + CNT_W'(1);
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_ff_num     <= r_num;
            r_ff_out     <= dut_out;
          end
        end
        // num holds at 15 once the last vector is checked.
        if (r_num != NUM_LAST) begin
          r_num    <= r_num + NUM_W'(1);
          r_settle <= '0;
        end
      end
    end
  end

  assign num            = r_num;
  assign busy           = w_busy;
  assign done           = w_done;
  assign pass           = w_pass;
  assign err_count      = r_err;
  assign fail_valid     = r_fail_valid;
  assign first_fail_num = r_ff_num;
  assign first_fail_out = r_ff_out;

endmodule

// File: tb/tb_ineq_sweep_checker.sv
// Scoreboard bench: drivers queue expected sweep results, monitors check on done.
module tb_ineq_sweep_checker;

  typedef struct {
    int         cycles;
    logic [4:0] err;
    logic       pass;
    logic       fv;
    logic [3:0] ffn;
    logic [2:0] ffo;
    bit         chk_ffo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [2];
  logic [2:0] dout  [2];
  logic [3:0] num   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [4:0] errc  [2];
  logic       fv    [2];
  logic [3:0] ffn   [2];
  logic [2:0] ffo   [2];
  int         mode  [2];
  int         start_cyc [2];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DUT: golden {n>=8,n>=4,n>=2} with selectable faults.
  function automatic logic [2:0] model(input int m, input logic [3:0] n);
    logic [2:0] g;
    g = {n >= 4'd8, n >= 4'd4, n >= 4'd2};
    case (m)
      1: g[0] = 1'b0;
      2: if (n == 4'd8) g = 3'b011;
      3: if (n == 4'd5) g = 3'bxx0;
      default: ;
    endcase
    return g;
  endfunction

  assign dout[0] = model(mode[0], num[0]);
  assign dout[1] = model(mode[1], num[1]);

  ineq_sweep_checker #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .dut_out(dout[0]),
    .num(num[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .fail_valid(fv[0]),
    .first_fail_num(ffn[0]), .first_fail_out(ffo[0])
  );

  ineq_sweep_checker #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .dut_out(dout[1]),
    .num(num[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .fail_valid(fv[1]),
    .first_fail_num(ffn[1]), .first_fail_out(ffo[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input int s, input string tag);
    check({tag, "_num"},  32'(num[s]),  0);
    check({tag, "_busy"}, 32'(busy[s]), 0);
    check({tag, "_done"}, 32'(done[s]), 0);
    check({tag, "_pass"}, 32'(pass[s]), 0);
    check({tag, "_err"},  32'(errc[s]), 0);
    check({tag, "_fv"},   32'(fv[s]),   0);
    check({tag, "_ffn"},  32'(ffn[s]),  0);
    check({tag, "_ffo"},  32'(ffo[s]),  0);
  endtask

  // Called at a negedge; returns at the negedge where elapsed == 0.
  task automatic pulse_start(input int s);
    start_cyc[s] = cyc + 1;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input int limit);
    int k = 0;
    while (!done[s] && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done[s]) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout inst%0d: done=%0b after %0d cycles, required 1", s, done[s], limit);
    end
    @(negedge clk);
  endtask

  task automatic monitor(input int s);
    logic prev = 1'b0;
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (done[s] && !prev) begin
        have = 1'b0;
        if (s == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        if (s == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done inst%0d: done rose with no queued expectation", s);
        end else begin
          check($sformatf("sb%0d_cycles", s), 32'(cyc - start_cyc[s]), 32'(e.cycles));
          check($sformatf("sb%0d_err", s),    32'(errc[s]), 32'(e.err));
          check($sformatf("sb%0d_pass", s),   32'(pass[s]), 32'(e.pass));
          check($sformatf("sb%0d_fv", s),     32'(fv[s]),   32'(e.fv));
          check($sformatf("sb%0d_ffn", s),    32'(ffn[s]),  32'(e.ffn));
          if (e.chk_ffo) check($sformatf("sb%0d_ffo", s), 32'(ffo[s]), 32'(e.ffo));
          check($sformatf("sb%0d_busy", s),   32'(busy[s]), 0);
          check($sformatf("sb%0d_num", s),    32'(num[s]),  15);
        end
      end
      prev = done[s];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mode[0]  = 0;
    mode[1]  = 0;
    repeat (2) @(negedge clk);
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");
    reset = 1'b0;
    @(negedge clk);

    // Golden sweep with per-cycle NUM stepping.
    q_a.push_back('{48, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1});
    pulse_start(0);
    for (int e = 0; e < 48; e++) begin
      check($sformatf("t1_num_e%0d", e), 32'(num[0]), 32'(e / 3));
      check($sformatf("t1_busy_e%0d", e), 32'(busy[0]), 1);
      check($sformatf("t1_done_e%0d", e), 32'(done[0]), 0);
      @(negedge clk);
    end
    wait_done(0, 10);

    // OUT[0] stuck low; also restart from DONE clears results.
    mode[0] = 1;
    q_a.push_back('{48, 5'd14, 1'b0, 1'b1, 4'd2, 3'b000, 1'b1});
    pulse_start(0);
    check("t2_restart_done", 32'(done[0]), 0);
    check("t2_restart_err",  32'(errc[0]), 0);
    check("t2_restart_busy", 32'(busy[0]), 1);
    wait_done(0, 100);

    // Single fault at NUM=8, then results must hold.
    mode[0] = 2;
    q_a.push_back('{48, 5'd1, 1'b0, 1'b1, 4'd8, 3'b011, 1'b1});
    pulse_start(0);
    wait_done(0, 100);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t3_hold_done_%0d", k), 32'(done[0]), 1);
      check($sformatf("t3_hold_err_%0d", k),  32'(errc[0]), 1);
      check($sformatf("t3_hold_ffn_%0d", k),  32'(ffn[0]),  8);
      check($sformatf("t3_hold_ffo_%0d", k),  32'(ffo[0]),  3);
      check($sformatf("t3_hold_pass_%0d", k), 32'(pass[0]), 0);
      @(negedge clk);
    end

    // Reset mid-sweep aborts, then a clean sweep.
    mode[0] = 0;
    pulse_start(0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero(0, "t4_abort");
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(busy[0]), 0);
    check("t4_idle_done", 32'(done[0]), 0);
    q_a.push_back('{48, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1});
    pulse_start(0);
    wait_done(0, 100);

    // start while busy is ignored.
    q_a.push_back('{48, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1});
    pulse_start(0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (24) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("t5_busy_e30", 32'(busy[0]), 1);
    check("t5_num_e30",  32'(num[0]),  10);
    wait_done(0, 100);

    // SETTLE_CYCLES=1 with X at NUM=5.
    mode[1] = 3;
    q_b.push_back('{32, 5'd1, 1'b0, 1'b1, 4'd5, 3'd0, 1'b0});
    pulse_start(1);
    wait_done(1, 100);

    check("queue_a_drained", 32'(q_a.size()), 0);
    check("queue_b_drained", 32'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
